// File: rtl/pwm_cmd_ramp_if.sv
// Target-command handshake between the speed controller and the ramp block.
// The controller drives valid/data and the ramp block answers with ready.
interface pwm_cmd_ramp_if;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [15:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/pwm_cmd_ramp.sv
// Slew-rate limiter for the PWM command word. Reversals are sequenced as
// ramp to zero, dwell, flip direction, then ramp up.
module pwm_cmd_ramp #(
  parameter logic [14:0] STEP        = 15'd16,
  parameter int unsigned TICK_DIV    = 32'd200,
  parameter int unsigned DWELL_TICKS = 32'd66
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pwm_cmd_ramp_if.slave        s_tgt,
  output logic [15:0]          o_cmd_out,
  output logic                 o_busy,
  output logic                 o_at_target
);

  localparam int unsigned TICK_W  = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam int unsigned DWELL_W = (DWELL_TICKS > 32'd1) ? $clog2(DWELL_TICKS) : 32'd1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 32'd1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_DWELL     = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_tgt_dir;
  logic [14:0]          r_tgt_mag;
  logic                 r_dir;
  logic [14:0]          r_mag;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [DWELL_W-1:0]   r_dwell_cnt;

  state_t               w_state_nxt;
  logic                 w_dir_nxt;
  logic [14:0]          w_mag_nxt;
  logic [DWELL_W-1:0]   w_dwell_nxt;

  logic                 w_tick;
  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_rev;
  logic [15:0]          w_up_sum;
  logic [14:0]          w_up_mag;
  logic [14:0]          w_floor;
  logic [15:0]          w_floor_step;
  logic [14:0]          w_down_mag;

  assign w_tick  = (r_tick_cnt == TICK_LAST);
  assign w_ready = (r_state != ST_DWELL);
  assign w_xfer  = s_tgt.tgt_valid && w_ready;
  // A zero-magnitude target never asks for a direction change.
  assign w_rev   = (r_tgt_mag != 15'd0) && (r_tgt_dir != r_dir);

  // Step arithmetic is one bit wider so neither direction can wrap.
  assign w_up_sum     = {1'b0, r_mag} + {1'b0, STEP};
  assign w_up_mag     = (w_up_sum >= {1'b0, r_tgt_mag}) ? r_tgt_mag : w_up_sum[14:0];
  assign w_floor      = w_rev ? 15'd0 : r_tgt_mag;
  assign w_floor_step = {1'b0, w_floor} + {1'b0, STEP};
  assign w_down_mag   = ({1'b0, r_mag} >= w_floor_step) ? (r_mag - STEP) : w_floor;

  assign s_tgt.tgt_ready = w_ready;
  assign o_cmd_out       = {r_dir, r_mag};
  assign o_busy          = (r_state != ST_IDLE);
  assign o_at_target     = (r_state == ST_IDLE);

  // Next-state and next-output decode for the ramp sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_mag_nxt   = r_mag;
    w_dwell_nxt = r_dwell_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rev) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (r_mag < r_tgt_mag) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (r_mag > r_tgt_mag) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RAMP_UP: begin
        if (w_rev || (r_mag > r_tgt_mag)) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (r_mag == r_tgt_mag) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_mag_nxt = w_up_mag;
        end else begin
          w_mag_nxt = r_mag;
        end
      end
      ST_RAMP_DOWN: begin
        if (r_mag == w_floor) begin
          if (w_rev) begin
            w_state_nxt = ST_DWELL;
            w_dwell_nxt = {DWELL_W{1'b0}};
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_mag < w_floor) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (w_tick) begin
          w_mag_nxt = w_down_mag;
        end else begin
          w_mag_nxt = r_mag;
        end
      end
      ST_DWELL: begin
        if (w_tick) begin
          if (r_dwell_cnt == DWELL_LAST) begin
            w_dir_nxt   = r_tgt_dir;
            w_state_nxt = ST_IDLE;
          end else begin
            w_dwell_nxt = r_dwell_cnt + DWELL_W'(1);
          end
        end else begin
          w_dwell_nxt = r_dwell_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Free-running tick divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Target latch, loaded on every accepted handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt_dir <= 1'b0;
      r_tgt_mag <= 15'd0;
    end else if (w_xfer) begin
      r_tgt_dir <= s_tgt.tgt_data[15];
      r_tgt_mag <= s_tgt.tgt_data[14:0];
    end else begin
      r_tgt_dir <= r_tgt_dir;
      r_tgt_mag <= r_tgt_mag;
    end
  end

  // Sequencer state and output command registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_mag       <= 15'd0;
      r_dwell_cnt <= {DWELL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_mag       <= w_mag_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_cmd_ramp.sv
// Bench for pwm_cmd_ramp: directed scenarios plus random targets, each checked
// cycle by cycle against an arithmetic prediction of every command change.
module tb_pwm_cmd_ramp;

  localparam int          STEP_I = 100;
  localparam logic [14:0] STEP   = 15'd100;
  localparam int          TD     = 4;
  localparam int          DW     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_out;
  logic        busy;
  logic        at_target;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        m_dir;
  int          m_mag;
  int          t0;

  pwm_cmd_ramp_if tgt_if ();

  pwm_cmd_ramp #(.STEP(STEP), .TICK_DIV(TD), .DWELL_TICKS(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_tgt       (tgt_if.slave),
    .o_cmd_out   (cmd_out),
    .o_busy      (busy),
    .o_at_target (at_target)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the tick divider restarts with it.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // First tick edge at or after edge x.
  function automatic int nt(input int x);
    return ((x + TD - 1) / TD) * TD;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    tgt_if.tgt_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_dir = 1'b0;
    m_mag = 0;
  endtask

  task automatic wait_cmd(input logic [15:0] v, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cmd_out === v) break;
    end
    check("wait_cmd", cmd_out, v);
  endtask

  // Send a target from idle and check every command change, its edge, and status each cycle.
  task automatic txn(input logic [15:0] d, input bit poke);
    int         ev[$];
    logic [15:0] val[$];
    int         n, z, f, last, cur, goal, t, idx, k, endc, tmag;
    logic       tdir;
    bit         rev;
    logic [15:0] prev;
    tdir = d[15];
    tmag = int'(d[14:0]);
    z = -1;
    f = -1;
    idx = 0;
    check("pre_ready", tgt_if.tgt_ready, 1);
    check("pre_at_target", at_target, 1);
    rev  = (tmag != 0) && (tdir != m_dir);
    n    = cyc + 1;
    goal = rev ? 0 : tmag;
    cur  = m_mag;
    t    = n;
    while (cur != goal) begin
      if (cur < goal) cur = (cur + STEP_I > goal) ? goal : cur + STEP_I;
      else            cur = (cur - STEP_I < goal) ? goal : cur - STEP_I;
      t = (ev.size() == 0) ? nt(n + 2) : t + TD;
      val.push_back({m_dir, 15'(cur)});
      ev.push_back(t);
    end
    if (rev) begin
      z = (m_mag == 0) ? n + 1 : t;
      f = nt(z + 2) + (DW - 1) * TD;
      val.push_back({tdir, 15'd0});
      ev.push_back(f);
      t = f;
      while (cur < tmag) begin
        cur = (cur + STEP_I > tmag) ? tmag : cur + STEP_I;
        t = (t == f) ? nt(f + 2) : t + TD;
        val.push_back({tdir, 15'(cur)});
        ev.push_back(t);
      end
    end
    last = (ev.size() > 0) ? ev[ev.size() - 1] : n;
    endc = last + 3;
    prev = cmd_out;
    tgt_if.tgt_data  = d;
    tgt_if.tgt_valid = 1'b1;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    for (int guard = 0; guard < 5000; guard++) begin
      k = cyc;
      if (cmd_out !== prev) begin
        if (idx < val.size()) begin
          check("value", cmd_out, val[idx]);
          check("edge", k, ev[idx]);
        end else begin
          check("extra_change", cmd_out, prev);
        end
        idx++;
        prev = cmd_out;
      end
      check("at_target", at_target, !(k >= n + 1 && k <= last && k != f));
      check("busy", busy, (k >= n + 1 && k <= last && k != f));
      check("ready", tgt_if.tgt_ready, !(z >= 0 && k >= z + 1 && k <= f - 1));
      if (k >= endc) break;
      if (poke && !tgt_if.tgt_ready) begin
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 16'($urandom);
      end else begin
        tgt_if.tgt_valid = 1'b0;
      end
      @(negedge clk);
    end
    tgt_if.tgt_valid = 1'b0;
    check("change_count", idx, val.size());
    m_dir = rev ? tdir : m_dir;
    m_mag = tmag;
    check("final_cmd", cmd_out, {m_dir, 15'(m_mag)});
  endtask

  initial begin
    rst = 1'b1;
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_data  = 16'h0000;

    // Reset state
    do_reset(3);
    check("rst_cmd", cmd_out, 16'h0000);
    check("rst_ready", tgt_if.tgt_ready, 1);
    check("rst_at_target", at_target, 1);
    check("rst_busy", busy, 0);

    // Ramp-up with saturation at 350
    txn(16'h015E, 1'b0);
    check("ramp350", cmd_out, 16'h015E);

    // Reversal 400 forward -> 200 reverse, with valid pushed during the dwell
    txn(16'h0190, 1'b0);
    txn(16'h80C8, 1'b1);
    check("reversal", cmd_out, 16'h80C8);

    // Retarget mid-ramp: heading to 1000, drop to 100 at mag 200
    txn(16'h8000, 1'b0);
    tgt_if.tgt_data  = 16'h83E8;
    tgt_if.tgt_valid = 1'b1;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    wait_cmd(16'h80C8, 40);
    t0 = cyc;
    tgt_if.tgt_data  = 16'h8064;
    tgt_if.tgt_valid = 1'b1;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_out !== 16'h80C8) break;
      check("retarget_ready", tgt_if.tgt_ready, 1);
      @(negedge clk);
    end
    check("retarget_val", cmd_out, 16'h8064);
    check("retarget_edge", cyc, t0 + TD);
    @(negedge clk);
    check("retarget_at_target", at_target, 1);
    check("retarget_busy", busy, 0);
    m_dir = 1'b1;
    m_mag = 100;

    // Reset during RAMP_UP at mag 300, then the tick phase restarts
    do_reset(1);
    tgt_if.tgt_data  = 16'h03E8;
    tgt_if.tgt_valid = 1'b1;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    wait_cmd(16'h012C, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstramp_cmd", cmd_out, 16'h0000);
    check("rstramp_at_target", at_target, 1);
    check("rstramp_busy", busy, 0);
    m_dir = 1'b0;
    m_mag = 0;
    txn(16'h0064, 1'b0);

    // Reset during DWELL
    tgt_if.tgt_data  = 16'h8064;
    tgt_if.tgt_valid = 1'b1;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!tgt_if.tgt_ready) break;
      @(negedge clk);
    end
    check("dwell_reached", tgt_if.tgt_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdwell_cmd", cmd_out, 16'h0000);
    check("rstdwell_ready", tgt_if.tgt_ready, 1);
    check("rstdwell_busy", busy, 0);
    m_dir = 1'b0;
    m_mag = 0;

    // Zero-magnitude reverse target is a no-op
    txn(16'h8000, 1'b0);
    check("zero_mag", cmd_out, 16'h0000);

    // Random targets from idle
    for (int i = 0; i < 25; i++) begin
      logic [15:0] d;
      d[15]   = 1'($urandom);
      d[14:0] = ($urandom % 8 == 0) ? 15'd0 : 15'($urandom_range(0, 1200));
      txn(d, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
